seg7_scan_driver: RTL

Four-digit multiplexed seven-segment display driver that sits directly downstream of the cascaded BCD digit counters of the 0-to-9675 counter. Captures the four BCD digits into a shadow register on `load`, then time-multiplexes them onto one shared segment bus with one anode strobe per digit. A parameterised prescaler sets the refresh rate, and invalid BCD codes render as a dash.

---
 rtl/seg7_pkg.sv | 56 +++++
 rtl/seg7_scan_driver_bcd_to_seg7.sv | 27 ++
 rtl/seg7_scan_driver.sv | 98 +++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the seg7 scan driver.
// Patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  function automatic scan_t next_slot(
    input scan_t s
  );
    scan_t n;
    n = DIG0;
    unique case (s)
      DIG0: n = DIG1;
      DIG1: n = DIG2;
      DIG2: n = DIG3;
      DIG3: n = DIG0;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] slot_anode(
    input scan_t s
  );
    logic [3:0] a;
    a = 4'b1111;
    unique case (s)
      DIG0: a = 4'b1110;
      DIG1: a = 4'b1101;
      DIG2: a = 4'b1011;
      DIG3: a = 4'b0111;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// BCD to active-low seven-segment decoder.
// Codes above 9 render as a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// Optional leading-zero blanking via `define SEG7_LZB_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int DATA_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ena,
  input  logic                             load,
  input  logic [NUM_DIGITS*DATA_WIDTH-1:0] bcd_in,
  output logic [6:0]                       seg,
  output logic [3:0]                       an
);

  localparam int PW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(CLK_DIV - 1);
  localparam int SW = NUM_DIGITS * DATA_WIDTH;

  logic [PW-1:0]       cnt;
  logic                tick;
  scan_t               state;
  logic [SW-1:0]       shadow;
  logic [DATA_WIDTH-1:0] digit;
  logic [6:0]          dec;
  logic                lz;

  assign tick = ena && (cnt == TC);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ena) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIG0;
    end else if (tick) begin
      state <= next_slot(state);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= bcd_in;
    end
  end

  always_comb begin
    digit = '0;
    unique case (state)
      DIG0: digit = shadow[3:0];
      DIG1: digit = shadow[7:4];
      DIG2: digit = shadow[11:8];
      DIG3: digit = shadow[15:12];
    endcase
  end

  bcd_to_seg7 u_dec (
    .code (digit),
    .seg  (dec)
  );

`ifdef SEG7_LZB_EN
  // A slot blanks only when it and every higher digit are zero.
  always_comb begin
    lz = 1'b0;
    unique case (state)
      DIG0: lz = 1'b0;
      DIG1: lz = (shadow[15:4] == '0);
      DIG2: lz = (shadow[15:8] == '0);
      DIG3: lz = (shadow[15:12] == '0);
    endcase
  end
`else
  assign lz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= slot_anode(state);
      seg <= lz ? SEG_BLANK : dec;
    end
  end

endmodule
